// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_access_stage
// Description : EX/MEM pipeline register with a request/ack data-memory port.
//               Memory instructions stall upstream until the access is acked.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRegWrite,
    input  logic [1:0]  IRegStore,
    input  logic        IMemWrite,
    input  logic        IMemRead,
    input  logic [15:0] IPCP2,
    input  logic [15:0] IALUResult,
    input  logic [15:0] I3rdArg,
    input  logic [2:0]  IRd,
    input  logic        IMemAck,
    input  logic [15:0] IMemRData,
    output logic        ORegWrite,
    output logic [1:0]  ORegStore,
    output logic [15:0] OPCP2,
    output logic [15:0] OALUResult,
    output logic [15:0] OLoadData,
    output logic [2:0]  ORd,
    output logic        OMemReq,
    output logic        OMemWE,
    output logic [15:0] OMemAddr,
    output logic [15:0] OMemWData,
    output logic        OStall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        reg_write_q, reg_write_d;
    logic [1:0]  reg_store_q, reg_store_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_read_q,  mem_read_d;
    logic [15:0] pcp2_q,      pcp2_d;
    logic [15:0] alu_q,       alu_d;
    logic [15:0] arg3_q,      arg3_d;
    logic [2:0]  rd_q,        rd_d;
    logic [15:0] load_q,      load_d;

    logic        in_req;

    assign in_req = (state_q == ST_REQ);

    always_comb begin
        state_d     = state_q;
        reg_write_d = reg_write_q;
        reg_store_d = reg_store_q;
        mem_write_d = mem_write_q;
        mem_read_d  = mem_read_q;
        pcp2_d      = pcp2_q;
        alu_d       = alu_q;
        arg3_d      = arg3_q;
        rd_d        = rd_q;
        load_d      = load_q;

        if (!in_req) begin
            reg_write_d = IRegWrite;
            reg_store_d = IRegStore;
            mem_write_d = IMemWrite;
            mem_read_d  = IMemRead;
            pcp2_d      = IPCP2;
            alu_d       = IALUResult;
            arg3_d      = I3rdArg;
            rd_d        = IRd;
            state_d     = (IMemRead || IMemWrite) ? ST_REQ : ST_IDLE;
        end else if (IMemAck) begin
            state_d = ST_DONE;
            // Read+write together behaves as a store, so no load capture.
            if (mem_read_q && !mem_write_q) begin
                load_d = IMemRData;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            reg_write_q <= 1'b0;
            reg_store_q <= 2'd0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            pcp2_q      <= 16'd0;
            alu_q       <= 16'd0;
            arg3_q      <= 16'd0;
            rd_q        <= 3'd0;
            load_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            reg_write_q <= reg_write_d;
            reg_store_q <= reg_store_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            pcp2_q      <= pcp2_d;
            alu_q       <= alu_d;
            arg3_q      <= arg3_d;
            rd_q        <= rd_d;
            load_q      <= load_d;
        end
    end

    // Writeback sees a bubble while the access is outstanding.
    assign ORegWrite  = reg_write_q && !in_req;
    assign ORegStore  = reg_store_q;
    assign OPCP2      = pcp2_q;
    assign OALUResult = alu_q;
    assign OLoadData  = load_q;
    assign ORd        = rd_q;

    assign OMemReq    = in_req;
    assign OMemWE     = in_req && mem_write_q;
    assign OMemAddr   = alu_q;
    assign OMemWData  = arg3_q;
    assign OStall     = in_req;

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_access_stage
// Description : Directed scoreboard bench for memory_access_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

    typedef struct packed {
        logic        rw;
        logic [1:0]  rs;
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] ld;
        logic [2:0]  rd;
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wd;
        logic        st;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IRegWrite = 1'b0;
    logic [1:0]  IRegStore = 2'd0;
    logic        IMemWrite = 1'b0;
    logic        IMemRead = 1'b0;
    logic [15:0] IPCP2 = 16'd0;
    logic [15:0] IALUResult = 16'd0;
    logic [15:0] I3rdArg = 16'd0;
    logic [2:0]  IRd = 3'd0;
    logic        IMemAck = 1'b0;
    logic [15:0] IMemRData = 16'd0;
    logic        ORegWrite;
    logic [1:0]  ORegStore;
    logic [15:0] OPCP2;
    logic [15:0] OALUResult;
    logic [15:0] OLoadData;
    logic [2:0]  ORd;
    logic        OMemReq;
    logic        OMemWE;
    logic [15:0] OMemAddr;
    logic [15:0] OMemWData;
    logic        OStall;

    int checks = 0;
    int failures = 0;

    exp_t  exp_q[$];
    string name_q[$];

    memory_access_stage dut (
        .clk(clk), .reset(reset),
        .IRegWrite(IRegWrite), .IRegStore(IRegStore), .IMemWrite(IMemWrite),
        .IMemRead(IMemRead), .IPCP2(IPCP2), .IALUResult(IALUResult),
        .I3rdArg(I3rdArg), .IRd(IRd), .IMemAck(IMemAck), .IMemRData(IMemRData),
        .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OPCP2(OPCP2),
        .OALUResult(OALUResult), .OLoadData(OLoadData), .ORd(ORd),
        .OMemReq(OMemReq), .OMemWE(OMemWE), .OMemAddr(OMemAddr),
        .OMemWData(OMemWData), .OStall(OStall)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic rw, input logic [1:0] rs,
                                input logic [15:0] pc, input logic [15:0] alu,
                                input logic [15:0] ld, input logic [2:0] rd,
                                input logic req, input logic we,
                                input logic [15:0] addr, input logic [15:0] wd,
                                input logic st);
        exp_t e;
        e.rw = rw; e.rs = rs; e.pc = pc; e.alu = alu; e.ld = ld; e.rd = rd;
        e.req = req; e.we = we; e.addr = addr; e.wd = wd; e.st = st;
        return e;
    endfunction

    // Memory address/data are only meaningful while a request is presented.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            logic  bad;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{ORegWrite, ORegStore, OPCP2, OALUResult, OLoadData, ORd,
                  OMemReq, OMemWE, OMemAddr, OMemWData, OStall};
            bad = (a.rw !== e.rw) || (a.rs !== e.rs) || (a.pc !== e.pc) ||
                  (a.alu !== e.alu) || (a.ld !== e.ld) || (a.rd !== e.rd) ||
                  (a.req !== e.req) || (a.we !== e.we) || (a.st !== e.st) ||
                  (e.req && ((a.addr !== e.addr) || (a.wd !== e.wd)));
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL %s: actual rw=%b rs=%0d pc=%h alu=%h ld=%h rd=%0d req=%b we=%b addr=%h wd=%h st=%b required rw=%b rs=%0d pc=%h alu=%h ld=%h rd=%0d req=%b we=%b addr=%h wd=%h st=%b",
                         n, a.rw, a.rs, a.pc, a.alu, a.ld, a.rd, a.req, a.we, a.addr, a.wd, a.st,
                         e.rw, e.rs, e.pc, e.alu, e.ld, e.rd, e.req, e.we, e.addr, e.wd, e.st);
            end
        end
    end

    task automatic drive(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic mr, input logic [15:0] pc, input logic [15:0] alu,
                         input logic [15:0] a3, input logic [2:0] rd,
                         input logic ack, input logic [15:0] rdata);
        IRegWrite = rw; IRegStore = rs; IMemWrite = mw; IMemRead = mr;
        IPCP2 = pc; IALUResult = alu; I3rdArg = a3; IRd = rd;
        IMemAck = ack; IMemRData = rdata;
    endtask

    task automatic expect_next(input exp_t e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic step(input logic rw, input logic [1:0] rs, input logic mw,
                        input logic mr, input logic [15:0] pc, input logic [15:0] alu,
                        input logic [15:0] a3, input logic [2:0] rd,
                        input logic ack, input logic [15:0] rdata,
                        input exp_t e, input string n);
        drive(rw, rs, mw, mr, pc, alu, a3, rd, ack, rdata);
        expect_next(e, n);
        @(negedge clk);
        #1;
    endtask

    exp_t zero;

    initial begin
        zero = '0;
        @(negedge clk);
        #1;
        step(1, 2'd1, 0, 1, 16'h0002, 16'h5555, 16'h0, 3'd7, 0, 16'h0, zero, "rst_hold");
        reset = 1'b0;

        // ALU op
        step(1, 2'd0, 0, 0, 16'h0002, 16'h1234, 16'h0, 3'd3, 0, 16'h0,
             mk(1, 2'd0, 16'h0002, 16'h1234, 16'h0, 3'd3, 0, 0, 16'h0, 16'h0, 0), "alu_op");

        // Load, acked on first REQ cycle; new inputs ignored while stalled
        step(1, 2'd1, 0, 1, 16'h0004, 16'h0040, 16'h0, 3'd5, 0, 16'h0,
             mk(0, 2'd1, 16'h0004, 16'h0040, 16'h0, 3'd5, 1, 0, 16'h0040, 16'h0, 1), "load_req");
        step(0, 2'd0, 0, 0, 16'h0099, 16'h9999, 16'h0, 3'd1, 1, 16'hBEEF,
             mk(1, 2'd1, 16'h0004, 16'h0040, 16'hBEEF, 3'd5, 0, 0, 16'h0, 16'h0, 0), "load_done");

        // Store, acked after 3 REQ cycles; ack at the DONE-edge is ignored
        step(0, 2'd0, 1, 0, 16'h0006, 16'h0008, 16'h00FF, 3'd0, 1, 16'h1111,
             mk(0, 2'd0, 16'h0006, 16'h0008, 16'hBEEF, 3'd0, 1, 1, 16'h0008, 16'h00FF, 1), "store_req1");
        step(1, 2'd2, 0, 1, 16'h0077, 16'hDEAD, 16'h1234, 3'd6, 0, 16'h0,
             mk(0, 2'd0, 16'h0006, 16'h0008, 16'hBEEF, 3'd0, 1, 1, 16'h0008, 16'h00FF, 1), "store_req2");
        step(1, 2'd2, 0, 1, 16'h0077, 16'hDEAD, 16'h1234, 3'd6, 0, 16'h0,
             mk(0, 2'd0, 16'h0006, 16'h0008, 16'hBEEF, 3'd0, 1, 1, 16'h0008, 16'h00FF, 1), "store_req3");
        step(0, 2'd0, 0, 0, 16'h0000, 16'h0000, 16'h0, 3'd0, 1, 16'h2222,
             mk(0, 2'd0, 16'h0006, 16'h0008, 16'hBEEF, 3'd0, 0, 0, 16'h0, 16'h0, 0), "store_done");

        // Read+write together behaves as a store
        step(1, 2'd1, 1, 1, 16'h0008, 16'h0010, 16'h0A0A, 3'd2, 0, 16'h0,
             mk(0, 2'd1, 16'h0008, 16'h0010, 16'hBEEF, 3'd2, 1, 1, 16'h0010, 16'h0A0A, 1), "rmw_req");
        step(0, 2'd0, 0, 0, 16'h0000, 16'h0000, 16'h0, 3'd0, 1, 16'h3333,
             mk(1, 2'd1, 16'h0008, 16'h0010, 16'hBEEF, 3'd2, 0, 0, 16'h0, 16'h0, 0), "rmw_done");

        // Stray acks outside REQ
        step(1, 2'd2, 0, 0, 16'h000A, 16'h00AA, 16'h0, 3'd4, 1, 16'hAAAA,
             mk(1, 2'd2, 16'h000A, 16'h00AA, 16'hBEEF, 3'd4, 0, 0, 16'h0, 16'h0, 0), "idle_ack1");
        step(0, 2'd3, 0, 0, 16'h000C, 16'h0BBB, 16'h0, 3'd6, 1, 16'hAAAA,
             mk(0, 2'd3, 16'h000C, 16'h0BBB, 16'hBEEF, 3'd6, 0, 0, 16'h0, 16'h0, 0), "idle_ack2");

        // Load with a wait cycle; read data without ack must not be captured
        step(1, 2'd1, 0, 1, 16'h000E, 16'h0044, 16'h0, 3'd1, 0, 16'h0,
             mk(0, 2'd1, 16'h000E, 16'h0044, 16'hBEEF, 3'd1, 1, 0, 16'h0044, 16'h0, 1), "load2_req");
        step(0, 2'd0, 0, 0, 16'h0000, 16'h0000, 16'h0, 3'd0, 0, 16'h5A5A,
             mk(0, 2'd1, 16'h000E, 16'h0044, 16'hBEEF, 3'd1, 1, 0, 16'h0044, 16'h0, 1), "load2_wait");
        step(0, 2'd0, 0, 0, 16'h0000, 16'h0000, 16'h0, 3'd0, 1, 16'hC0DE,
             mk(1, 2'd1, 16'h000E, 16'h0044, 16'hC0DE, 3'd1, 0, 0, 16'h0, 16'h0, 0), "load2_done");

        // Reset asserted mid-REQ, between clock edges
        step(1, 2'd1, 0, 1, 16'h0010, 16'h0080, 16'h0, 3'd7, 0, 16'h0,
             mk(0, 2'd1, 16'h0010, 16'h0080, 16'hC0DE, 3'd7, 1, 0, 16'h0080, 16'h0, 1), "abort_req");
        drive(0, 2'd0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0, 0, 16'h0);
        expect_next(zero, "rst_async");
        @(posedge clk);
        #1;
        reset = 1'b1;
        IMemAck = 1'b1;
        IMemRData = 16'hFFFF;
        @(negedge clk);
        #1;
        step(0, 2'd0, 0, 1, 16'h0000, 16'h0000, 16'h0, 3'd0, 1, 16'hFFFF, zero, "rst_held");
        reset = 1'b0;
        step(1, 2'd2, 0, 0, 16'h0020, 16'h4321, 16'h0, 3'd2, 0, 16'h0,
             mk(1, 2'd2, 16'h0020, 16'h4321, 16'h0, 3'd2, 0, 0, 16'h0, 16'h0, 0), "post_rst");

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: actual pending=%0d required pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high; ports named clk and reset.
REQ-002 SHALL have ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- IRegWrite  in  1  EX reg-write control
- IRegStore  in  2  EX writeback-source select
- IMemWrite  in  1  EX store control
- IMemRead  in  1  EX load control
- IPCP2  in  16  EX PC+2
- IALUResult  in  16  EX ALU result / memory address
- I3rdArg  in  16  EX store data
- IRd  in  3  EX destination register
- IMemAck  in  1  data-memory access complete
- IMemRData  in  16  data-memory read data, valid with IMemAck
- ORegWrite  out  1  reg-write to WB, bubble-gated
- ORegStore  out  2  registered IRegStore
- OPCP2  out  16  registered IPCP2
- OALUResult  out  16  registered IALUResult, also MEM forwarding source
- OLoadData  out  16  captured load data
- ORd  out  3  registered IRd
- OMemReq  out  1  data-memory request
- OMemWE  out  1  data-memory write enable
- OMemAddr  out  16  data-memory address
- OMemWData  out  16  data-memory write data
- OStall  out  1  upstream pipeline hold

Function
REQ-003 SHALL contain an EX/MEM register (all I* fields above except IMemAck/IMemRData) loading on each rising clk when OStall=0 and holding when OStall=1.
REQ-004 SHALL implement FSM states IDLE, REQ, DONE.
REQ-005 On a load of the register: next state REQ if loaded IMemRead or IMemWrite=1, else IDLE.
REQ-006 In REQ: OMemReq=1, OMemAddr=registered ALU result, OStall=1; when IMemAck=1 sampled at clk edge, next state DONE, else stay REQ.
REQ-007 OMemWE SHALL be 1 only in REQ with registered MemWrite=1; OMemWData=registered 3rd arg whenever in REQ.
REQ-008 MemWrite and MemRead both set SHALL be treated as a store: OMemWE=1, OLoadData not updated.
REQ-009 On REQ with IMemAck=1 and registered MemRead=1 (MemWrite=0), OLoadData register SHALL capture IMemRData at that edge.
REQ-010 In IDLE and DONE: OMemReq=0, OMemWE=0, OStall=0; register loads the next instruction.
REQ-011 ORegWrite SHALL equal registered RegWrite in IDLE and DONE and be forced 0 in REQ (bubble to WB).
REQ-012 OALUResult, OPCP2, ORegStore, ORd SHALL always reflect the register contents, including in REQ.
REQ-013 Latency: non-memory instruction occupies 1 cycle; memory instruction occupies (cycles until ack, min 1) + 1 DONE cycle, min 2.
REQ-014 IMemAck outside REQ SHALL be ignored; IMemRData outside REQ-with-ack SHALL not affect OLoadData.
REQ-015 OMemReq, OMemWE, OStall SHALL be decoded from state and register only (no combinational path from IMemAck).

Reset
REQ-016 reset=1 SHALL asynchronously clear the EX/MEM register and OLoadData to 0 and force state IDLE; all outputs 0.
REQ-017 Reset in REQ SHALL abort the access: OMemReq and OStall drop to 0 without waiting for clk; no load data captured.
REQ-018 After reset release, the first rising clk SHALL load the register normally.

Verification
REQ-019 ALU op IALUResult=0x1234, IRd=3, IRegWrite=1 -> next cycle ORegWrite=1, OALUResult=0x1234, ORd=3, OMemReq=0, OStall=0.
REQ-020 Load addr 0x0040, ack 1st REQ cycle with IMemRData=0xBEEF -> cycle1 OMemReq=1, OStall=1, ORegWrite=0; cycle2 DONE, OLoadData=0xBEEF, ORegWrite=1, OStall=0.
REQ-021 Store addr 0x0008 data 0x00FF, ack after 3 cycles -> OMemReq=OMemWE=1, OMemWData=0x00FF for 3 cycles; register holds, new inputs ignored; OLoadData unchanged.
REQ-022 IMemRead=IMemWrite=1 -> OMemWE=1, OLoadData unchanged after ack.
REQ-023 Stray IMemAck=1, IMemRData=0xAAAA during IDLE -> OLoadData unchanged, state IDLE.
REQ-024 reset asserted mid-REQ between edges -> OMemReq=0, OStall=0 immediately; all outputs 0; next instruction loads on first clk after release.
